// File: rtl/spi_pkg.sv
// Shared types and helpers for the second-generation SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    DONE
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  // A zero or oversized length request runs as a full-width transfer.
  function automatic int unsigned eff_len(input int unsigned len_in, input int unsigned max_len);
    if (len_in == 0 || len_in > max_len) return max_len;
    return len_in;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period divider, SCK toggling and leading/trailing edge strobes.
module spi_sck_gen #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 edge_en,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 cpol,
  output logic                 spi_sck,
  output logic                 lead_strobe_c,
  output logic                 trail_strobe_c,
  output logic                 tick_c
);

  logic [DIV_WIDTH-1:0] div_cnt;

  // Strobes mark the cycle whose closing clk edge drives the SCK transition.
  assign tick_c         = enable && (div_cnt == clk_div);
  assign lead_strobe_c  = tick_c && edge_en && (spi_sck == cpol);
  assign trail_strobe_c = tick_c && edge_en && (spi_sck != cpol);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      spi_sck <= 1'b0;
    end else begin
      if (!enable || tick_c) div_cnt <= '0;
      else                   div_cnt <= div_cnt + DIV_WIDTH'(1);

      if (!enable)                spi_sck <= cpol;
      else if (tick_c && edge_en) spi_sck <= ~spi_sck;
    end
  end

endmodule

// File: rtl/spi_master_gen2.sv
// Parametrised SPI master: all four modes, runtime length, bit order, divider and one-hot CS.
module spi_master_gen2
  import spi_pkg::*;
#(
  parameter int unsigned MAX_DATA_LENGTH = 32,
  parameter int unsigned NUM_CS          = 4,
  parameter int unsigned DIV_WIDTH       = 8,
  localparam int unsigned LEN_W          = $clog2(MAX_DATA_LENGTH + 1),
  localparam int unsigned CS_W           = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic                       lsb_first,
  input  logic [LEN_W-1:0]           len,
  input  logic [DIV_WIDTH-1:0]       clk_div,
  input  logic [CS_W-1:0]            cs_sel,
  input  logic [MAX_DATA_LENGTH-1:0] tx_data,
  output logic [MAX_DATA_LENGTH-1:0] rx_data,
  output logic                       busy,
  output logic                       done,
  output logic                       spi_sck,
  output logic [NUM_CS-1:0]          spi_cs_n,
  output logic                       spi_mosi,
  input  logic                       spi_miso
);

  localparam int unsigned CNT_W = $clog2(2 * MAX_DATA_LENGTH + 1);

  spi_state_t                 state, state_nxt;
  spi_mode_t                  mode_q;
  logic [LEN_W-1:0]           len_q, len_eff_c;
  logic [DIV_WIDTH-1:0]       div_q;
  logic [CS_W-1:0]            cs_q, cs_eff_c, cs_idx_c;
  logic [MAX_DATA_LENGTH-1:0] tx_sh, rx_sh, tx_aligned_c;
  logic [CNT_W-1:0]           edge_cnt, last_cnt_c;
  logic                       tick_c, lead_c, trail_c, last_edge_c;
  logic                       run_c, edges_c, busy_nxt_c, sck_cpol_c;
  logic                       first_bit_c, out_bit_c;

  assign len_eff_c  = LEN_W'(eff_len(32'(len), MAX_DATA_LENGTH));
  assign cs_eff_c   = (32'(cs_sel) >= NUM_CS) ? '0 : cs_sel;
  assign cs_idx_c   = (state == IDLE) ? cs_eff_c : cs_q;
  assign run_c      = state inside {SETUP, TRANSFER, HOLD};
  assign edges_c    = state inside {SETUP, TRANSFER};
  assign busy_nxt_c = state_nxt inside {SETUP, TRANSFER, HOLD};
  assign sck_cpol_c = (state == IDLE) ? cpol : mode_q.cpol;

  // MSB-first words are pre-aligned to the top so the shift register always emits from one end.
  assign tx_aligned_c = lsb_first ? tx_data
                                  : (tx_data << (MAX_DATA_LENGTH - 32'(len_eff_c)));
  assign first_bit_c  = lsb_first ? tx_aligned_c[0] : tx_aligned_c[MAX_DATA_LENGTH-1];
  assign out_bit_c    = mode_q.lsb_first ? tx_sh[0] : tx_sh[MAX_DATA_LENGTH-1];

  assign last_cnt_c  = CNT_W'({len_q, 1'b0}) - CNT_W'(1);
  assign last_edge_c = (state == TRANSFER) && (edge_cnt == last_cnt_c);

  spi_sck_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_sck_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (run_c),
    .edge_en        (edges_c),
    .clk_div        (div_q),
    .cpol           (sck_cpol_c),
    .spi_sck        (spi_sck),
    .lead_strobe_c  (lead_c),
    .trail_strobe_c (trail_c),
    .tick_c         (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SETUP;
      SETUP:    if (tick_c) state_nxt = TRANSFER;
      TRANSFER: if (tick_c && last_edge_c) state_nxt = HOLD;
      HOLD:     if (tick_c) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath and registered bus outputs, all aligned with the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      len_q    <= '0;
      div_q    <= '0;
      cs_q     <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs_n <= '1;
      spi_mosi <= 1'b0;
    end else begin
      busy     <= busy_nxt_c;
      done     <= (state_nxt == DONE);
      spi_cs_n <= busy_nxt_c ? ~(NUM_CS'(1) << cs_idx_c) : '1;

      case (state)
        IDLE: begin
          edge_cnt <= '0;
          if (start) begin
            mode_q <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
            len_q  <= len_eff_c;
            div_q  <= clk_div;
            cs_q   <= cs_eff_c;
            rx_sh  <= '0;
            if (!cpha) begin
              spi_mosi <= first_bit_c;
              tx_sh    <= lsb_first ? (tx_aligned_c >> 1) : (tx_aligned_c << 1);
            end else begin
              spi_mosi <= 1'b0;
              tx_sh    <= tx_aligned_c;
            end
          end
        end
        SETUP, TRANSFER: begin
          if (tick_c) edge_cnt <= edge_cnt + CNT_W'(1);
          // cpha selects whether leading or trailing edges sample; the other edge shifts.
          if ((lead_c && !mode_q.cpha) || (trail_c && mode_q.cpha)) begin
            rx_sh <= mode_q.lsb_first ? {spi_miso, rx_sh[MAX_DATA_LENGTH-1:1]}
                                      : {rx_sh[MAX_DATA_LENGTH-2:0], spi_miso};
          end
          if ((lead_c && mode_q.cpha) || (trail_c && !mode_q.cpha && !last_edge_c)) begin
            spi_mosi <= out_bit_c;
            tx_sh    <= mode_q.lsb_first ? (tx_sh >> 1) : (tx_sh << 1);
          end
        end
        HOLD: begin
          if (tick_c) begin
            spi_mosi <= 1'b0;
            rx_data  <= mode_q.lsb_first ? (rx_sh >> (MAX_DATA_LENGTH - 32'(len_q))) : rx_sh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen2.sv
// Randomized self-checking bench for spi_master_gen2 with a behavioural SPI slave model.
module tb_spi_master_gen2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cpol, cpha, lsb_first;
  logic [5:0]  len;
  logic [7:0]  clk_div;
  logic [1:0]  cs_sel;
  logic [31:0] tx_data, rx_data;
  logic        busy, done, spi_sck, spi_mosi, spi_miso;
  logic [3:0]  spi_cs_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model state and per-transfer observations
  logic        s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, lpbk = 1'b0;
  int          s_len = 8, s_cs = 0;
  logic [31:0] s_word = '0, m_word = '0;
  int          lead_n = 0, trail_n = 0, mosi_bad = 0, bit_i = 0, m_n = 0;
  logic        act_q = 1'b0, sck_q = 1'b0, mosi_q = 1'b0, slave_miso = 1'b0, entry_sck = 1'b0;

  always #5 clk = ~clk;

  assign spi_miso = lpbk ? spi_mosi : slave_miso;

  spi_master_gen2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .len       (len),
    .clk_div   (clk_div),
    .cs_sel    (cs_sel),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sbit(input int i);
    return s_word[s_lsb ? i : s_len - 1 - i];
  endfunction

  // Slave: drives miso on its shift edges, captures mosi on the master's sample edges.
  always @(negedge clk) begin : slave
    logic act, edge_seen, lead;
    act       = rst_n && (spi_cs_n[s_cs] == 1'b0);
    edge_seen = act && act_q && (spi_sck != sck_q);
    lead      = (sck_q == s_cpol);
    if (act && !act_q) begin
      bit_i = 0; m_n = 0; m_word = '0; lead_n = 0; trail_n = 0; mosi_bad = 0;
      entry_sck = spi_sck;
      if (!s_cpha) begin
        slave_miso = sbit(0);
        bit_i = 1;
      end
    end else if (act) begin
      if (spi_mosi != mosi_q && !(edge_seen && (lead == s_cpha))) mosi_bad++;
      if (edge_seen) begin
        if (lead) lead_n++;
        else      trail_n++;
        if (lead != s_cpha) begin
          if (m_n < s_len) m_word[s_lsb ? m_n : s_len - 1 - m_n] = spi_mosi;
          m_n++;
        end else if (bit_i < s_len) begin
          slave_miso = sbit(bit_i);
          bit_i++;
        end
      end
    end
    act_q  = act;
    sck_q  = spi_sck;
    mosi_q = spi_mosi;
  end

  // Called at a negedge in IDLE; returns at the negedge following the DONE cycle.
  task automatic run_xfer(input logic cp, input logic ph, input logic lsb, input int ln,
                          input int dv, input int cs, input logic [31:0] tx,
                          input logic [31:0] sw, input logic lp, input bit mid_start,
                          input bit done_start, input int abort_edge);
    int          l, h, exp_lat, busy_n, cs_bad, lat, toggles;
    logic        sck_p;
    logic [31:0] mask;
    logic [3:0]  exp_cs;
    l       = (ln == 0 || ln > 32) ? 32 : ln;
    h       = dv + 1;
    exp_lat = (2 * l + 1) * h + 1;
    mask    = (l == 32) ? 32'hFFFF_FFFF : ((32'h1 << l) - 32'h1);
    exp_cs  = ~(4'b0001 << cs);
    s_cpol = cp; s_cpha = ph; s_lsb = lsb; s_len = l; s_cs = cs;
    s_word = lp ? tx : sw; lpbk = lp;
    cpol = cp; cpha = ph; lsb_first = lsb; len = 6'(ln); clk_div = 8'(dv);
    cs_sel = 2'(cs); tx_data = tx; start = 1'b1;
    busy_n = 0; cs_bad = 0; lat = 0; toggles = 0; sck_p = cp;
    for (int i = 1; i <= exp_lat + 8; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (mid_start && i == 5) begin
        start = 1'b1; cpol = ~cp; cpha = ~ph; lsb_first = ~lsb;
        len = 6'($urandom_range(1, 40)); clk_div = 8'($urandom_range(0, 5));
        cs_sel = 2'(cs + 1); tx_data = $urandom;
      end
      if (mid_start && i == 6) start = 1'b0;
      if (busy) begin
        busy_n++;
        if (spi_cs_n != exp_cs) cs_bad++;
        if (spi_sck != sck_p) toggles++;
      end
      sck_p = spi_sck;
      if (abort_edge > 0 && toggles == abort_edge) begin
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", spi_cs_n, 4'hF);
        check("abort_sck", spi_sck, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rx", rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    if (abort_edge > 0) check("abort_reached", 0, 1);
    check("latency", lat, exp_lat);
    check("busy_cycles", busy_n, exp_lat - 1);
    check("cs_decode", cs_bad, 0);
    check("rx_data", rx_data, (lp ? tx : sw) & mask);
    check("mosi_word", m_word, tx & mask);
    check("lead_edges", lead_n, l);
    check("trail_edges", trail_n, l);
    check("sck_entry", entry_sck, cp);
    check("sck_done", spi_sck, cp);
    check("cs_done", spi_cs_n, 4'hF);
    check("mosi_done", spi_mosi, 0);
    check("mosi_stable", mosi_bad, 0);
    if (done_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_width", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    len = '0; clk_div = '0; cs_sel = '0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs_n", spi_cs_n, 4'hF);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_rx", rx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // cp ph lsb len div cs tx sw lp mid dstart abort
    run_xfer(0, 0, 0, 8,  1, 2, 32'h0000_00A5, 32'h0,         1, 0, 0, 0);
    run_xfer(1, 1, 0, 16, 0, 0, 32'h0000_1234, 32'h0000_BEEF, 0, 0, 0, 0);
    run_xfer(0, 1, 1, 8,  1, 1, 32'h0000_0001, 32'h0,         1, 0, 0, 0);
    run_xfer(1, 0, 1, 8,  1, 3, 32'h0000_0001, 32'h0,         1, 0, 0, 0);
    run_xfer(0, 0, 0, 0,  1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run_xfer(1, 1, 1, 40, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run_xfer(0, 1, 0, 12, 2, 2, 32'h0000_0ABC, 32'h0000_0531, 0, 1, 1, 0);
    run_xfer(1, 0, 0, 8,  0, 3, 32'h0000_003C, 32'h0000_00C3, 0, 0, 0, 0);
    run_xfer(0, 0, 0, 8,  1, 1, 32'h0000_005A, 32'h0000_0077, 0, 0, 0, 5);
    run_xfer(0, 0, 1, 8,  1, 1, 32'h0000_0096, 32'h0000_0069, 0, 0, 0, 0);

    for (int t = 0; t < 24; t++) begin
      run_xfer(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 40)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, $urandom,
               1'($urandom), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_gen2.md
Name: spi_master_gen2

Overview:
Parametrised second-generation SPI master. It supports all four SPI modes (CPOL/CPHA), a per-transfer length up to MAX_DATA_LENGTH, MSB- or LSB-first bit order, a runtime SCK divider, and NUM_CS one-hot chip selects. It sits between the host control logic and the external SPI bus, and replaces the fixed mode-0, fixed-length master for new designs.

Parameters:
MAX_DATA_LENGTH, 32, maximum bits per transfer; width of tx_data/rx_data.
NUM_CS, 4, number of chip-select outputs (must be >= 1).
DIV_WIDTH, 8, width of the runtime clock-divider input.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  transfer request; sampled only in IDLE.
cpol  input  1  SCK idle level.
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
lsb_first  input  1  1 = transmit/receive LSB first.
len  input  $clog2(MAX_DATA_LENGTH+1)  bits per transfer; 0 or >MAX is treated as MAX_DATA_LENGTH.
clk_div  input  DIV_WIDTH  SCK half-period H = clk_div+1 clk cycles.
cs_sel  input  max(1,$clog2(NUM_CS))  target slave index; values >= NUM_CS are treated as 0.
tx_data  input  MAX_DATA_LENGTH  transmit word, right-justified in [len-1:0].
rx_data  output  MAX_DATA_LENGTH  received word, right-justified, upper bits 0.
busy  output  1  transfer in progress.
done  output  1  one-cycle completion pulse.
spi_sck  output  1  SPI clock.
spi_cs_n  output  NUM_CS  active-low chip selects; at most one low.
spi_mosi  output  1  master out.
spi_miso  input  1  master in.

Behaviour:
- Clock/reset: one clock `clk`; `rst_n` is asynchronous, active-low. Reset is effective immediately, including mid-transfer: busy=0, done=0, spi_sck=0, spi_cs_n=all 1, spi_mosi=0, rx_data=0, state=IDLE, all counters 0. No partial rx_data is retained.
- FSM states: IDLE -> SETUP -> TRANSFER -> HOLD -> DONE -> IDLE.
- IDLE:
  - spi_sck follows the registered cpol input; spi_cs_n all 1; busy=0.
  - On start=1, latch cpol, cpha, lsb_first, effective len L, clk_div, cs_sel and tx_data; go to SETUP next cycle.
- SETUP (H cycles):
  - busy=1; the selected spi_cs_n bit is 0.
  - If cpha=0, drive the first data bit on spi_mosi on SETUP entry.
- TRANSFER:
  - Edge k (k=1..2L) occurs k*H cycles after SETUP entry. Odd k is a leading edge (SCK leaves cpol); even k is a trailing edge.
  - cpha=0: sample spi_miso on leading edges; shift the next bit out on trailing edges, except edge 2L.
  - cpha=1: shift out on leading edges, starting with the first bit at edge 1; sample on trailing edges.
  - Sampling and shifting take effect in the same clk cycle as the SCK edge is driven.
- HOLD: starts after edge 2L and lasts H cycles; spi_sck=cpol and CS remains asserted.
- DONE (1 cycle): busy=0, done=1, spi_cs_n all 1, spi_mosi=0, rx_data updated. The next cycle is IDLE, and start is accepted again from that cycle.
- Timing: busy is high for exactly (2L+1)*H cycles. done is high for exactly 1 cycle. Start-to-done latency is (2L+1)*H+1 cycles.
- Bit order:
  - MSB-first transmits tx_data[L-1] down to [0]; received bits fill rx_data[L-1] down to [0].
  - LSB-first reverses both orders.
  - In all cases rx_data[MAX-1:L]=0.
- start while busy, or in the DONE cycle, is ignored and not queued.
- Config input changes during a transfer have no effect, because all configuration is latched at start.
- The divider counter never exceeds the latched clk_div. clk_div=0 gives SCK = clk/2.

Decomposition:
- Package spi_pkg:
  - spi_state_t enum (IDLE, SETUP, TRANSFER, HOLD, DONE).
  - spi_mode_t packed struct {cpol, cpha, lsb_first}.
  - Helper function for effective-length clamping.
- Sub-module spi_sck_gen:
  - Inputs: enable, clk_div, cpol.
  - Outputs: spi_sck, lead_strobe, trail_strobe, half-period tick.
  - Contains the divider counter and edge detection.
  - The top level owns the FSM, shift registers, bit counter and CS decode.

Test Plan:
- Mode 0, L=8, clk_div=1, cs_sel=2, tx=0xA5, miso looped to mosi -> rx_data=0x000000A5; busy high for 34 cycles; spi_cs_n=4'b1011 during busy; 8 rising SCK edges; done one cycle.
- Mode 3, L=16, clk_div=0, tx=0x1234, slave model returns 0xBEEF -> rx_data=0x0000BEEF; SCK idles high before and after; MOSI changes only on falling edges.
- Modes 1 and 2, L=8, LSB-first, tx=0x01, loopback -> first bit on MOSI is 1; rx_data=0x01; a scoreboard checks sample/shift edge per mode.
- len=0 and len=40, tx=0xFFFF_FFFF -> both run as 32-bit transfers; busy = 65*H cycles; rx_data=0xFFFF_FFFF with miso tied 1.
- start pulsed again mid-transfer, and during the DONE cycle -> ignored; exactly one done pulse; new start in the following IDLE cycle accepted.
- rst_n low at edge 5 of an L=8 transfer -> same cycle: spi_cs_n all 1, spi_sck=0, busy=0, rx_data=0; after release, a fresh transfer completes correctly.
